// File: rtl/icb_blk_ctrl_hub_pkg.sv
// Shared definitions for the ICB block-control hub: register offsets,
// CTRL bit positions, channel state encoding and a byte-mask helper.
package panda_blk_ctrl_hub_pkg;

    // Offsets inside one channel window (channel c lives at c * CHN_STRIDE)
    localparam logic [4:0]  CTRL_OFS     = 5'h00;
    localparam logic [4:0]  PARAMS_OFS   = 5'h10;
    localparam logic [10:0] CHN_STRIDE   = 11'h020;

    // Global registers
    localparam logic [10:0] IRQ_EN_ADDR  = 11'h400;
    localparam logic [10:0] IRQ_STS_ADDR = 11'h404;

    // CTRL write bits
    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLR_BIT   = 1;
    // CTRL read bits
    localparam int CTRL_IDLE_BIT  = 0;
    localparam int CTRL_DONE_BIT  = 1;
    localparam int CTRL_BUSY_BIT  = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } chn_sts_e;

    // Expand 4 byte enables into a 32-bit bit mask
    function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
        logic [31:0] m;
        for (int b = 0; b < 4; b++) begin
            m[b*8 +: 8] = {8{wmask[b]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/icb_blk_ctrl_hub_if.sv
// ICB command/response bundle between the CPU bus and the block-control hub.
// slave  : the hub side (accepts commands, produces responses)
// master : the CPU / bench side
interface icb_blk_ctrl_hub_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] icb_cmd_addr;
    logic                  icb_cmd_read;
    logic [31:0]           icb_cmd_wdata;
    logic [3:0]            icb_cmd_wmask;
    logic                  icb_cmd_valid;
    logic                  icb_cmd_ready;
    logic [31:0]           icb_rsp_rdata;
    logic                  icb_rsp_err;
    logic                  icb_rsp_valid;
    logic                  icb_rsp_ready;

    modport slave (
        input  icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        input  icb_cmd_valid, icb_rsp_ready,
        output icb_cmd_ready, icb_rsp_rdata, icb_rsp_err, icb_rsp_valid
    );

    modport master (
        output icb_cmd_addr, icb_cmd_read, icb_cmd_wdata, icb_cmd_wmask,
        output icb_cmd_valid, icb_rsp_ready,
        input  icb_cmd_ready, icb_rsp_rdata, icb_rsp_err, icb_rsp_valid
    );
endinterface

// File: rtl/icb_blk_ctrl_hub_chn.sv
// One block-control channel: IDLE/BUSY FSM, params register, sticky done
// flag and the one-cycle start pulse.
// Ports: start_i/clr_done_i/par_we_i are already-qualified commands from the
// hub decoder; done_i is the raw block done pulse; done_evt_o flags a done
// that actually ended a BUSY period (feeds IRQ_STS).
module blk_ctrl_chn
    import panda_blk_ctrl_hub_pkg::*;
#(
    parameter int PARAMS_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start_i,
    input  logic                    clr_done_i,
    input  logic                    par_we_i,
    input  logic [1:0]              par_word_i,
    input  logic [31:0]             par_wdata_i,
    input  logic [31:0]             par_bmask_i,
    input  logic                    done_i,
    output logic                    busy_o,
    output logic                    done_sticky_o,
    output logic                    done_evt_o,
    output logic                    start_o,
    output logic [PARAMS_WIDTH-1:0] params_o
);
    localparam int NWORDS = PARAMS_WIDTH / 32;

    chn_sts_e                state_q, state_d;
    logic                    done_sticky_q, done_sticky_d;
    logic                    start_q;
    logic [PARAMS_WIDTH-1:0] params_q, params_d;
    logic                    is_idle_s;
    logic                    done_evt_s;

    assign is_idle_s  = (state_q == IDLE);
    assign done_evt_s = (state_q == BUSY) & done_i;

    // Channel state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Channel next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = BUSY;
                else         state_d = IDLE;
            end
            BUSY: begin
                if (done_i) state_d = IDLE;
                else        state_d = BUSY;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sticky done: a done in the same cycle as a clear keeps the flag set
    always_comb begin
        done_sticky_d = done_sticky_q;
        if (done_evt_s)      done_sticky_d = 1'b1;
        else if (clr_done_i) done_sticky_d = 1'b0;
        else                 done_sticky_d = done_sticky_q;
    end

    // Byte-merge of one params word; frozen while BUSY
    always_comb begin
        params_d = params_q;
        for (int k = 0; k < NWORDS; k++) begin
            if (par_we_i && is_idle_s && (int'(par_word_i) == k)) begin
                params_d[k*32 +: 32] = (params_q[k*32 +: 32] & ~par_bmask_i) |
                                       (par_wdata_i & par_bmask_i);
            end else begin
                params_d[k*32 +: 32] = params_q[k*32 +: 32];
            end
        end
    end

    // Status, params and start-pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_sticky_q <= 1'b0;
            params_q      <= '0;
            start_q       <= 1'b0;
        end else begin
            done_sticky_q <= done_sticky_d;
            params_q      <= params_d;
            start_q       <= start_i & is_idle_s;
        end
    end

    assign busy_o        = (state_q == BUSY);
    assign done_sticky_o = done_sticky_q;
    assign done_evt_o    = done_evt_s;
    assign start_o       = start_q;
    assign params_o      = params_q;

endmodule

// File: rtl/icb_blk_ctrl_hub.sv
// ICB register hub driving CHN_N block-control channels.
// Ports: clk/rst_n; bus (ICB slave); blk_params_o (channel c at
// [c*PARAMS_WIDTH +: PARAMS_WIDTH]); blk_start_o one-cycle start pulses;
// blk_idle_i / blk_done_i from the blocks; irq_o registered interrupt.
// Only address bits [10:2] are decoded.
module icb_blk_ctrl_hub
    import panda_blk_ctrl_hub_pkg::*;
#(
    parameter int CHN_N        = 4,
    parameter int PARAMS_WIDTH = 64,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    icb_blk_ctrl_hub_if.slave             bus,
    output logic [CHN_N*PARAMS_WIDTH-1:0] blk_params_o,
    output logic [CHN_N-1:0]              blk_start_o,
    input  logic [CHN_N-1:0]              blk_idle_i,
    input  logic [CHN_N-1:0]              blk_done_i,
    output logic                          irq_o
);
    localparam int NWORDS = PARAMS_WIDTH / 32;

    logic [10:0] addr_s;
    logic [4:0]  chn_sel_s;
    logic [4:0]  ofs_s;
    logic [1:0]  par_k_s;
    logic        chn_ok_s, is_ctrl_s, is_par_s, is_en_s, is_sts_s, mapped_s;
    logic        cmd_ready_s, cmd_acc_s, wr_s;
    logic        start_req_s, clr_req_s, start_bad_s, par_bad_s, err_s;
    logic [31:0] bmask_s, rdata_s, ctrl_rd_s;
    logic        sel_busy_s, sel_idle_s, sel_sticky_s;
    logic [31:0] sel_par_s;

    logic [CHN_N-1:0]                   busy_s, sticky_s, done_evt_s, start_s;
    logic [CHN_N-1:0][PARAMS_WIDTH-1:0] params_s;

    logic [CHN_N-1:0] irq_en_q, irq_en_d, irq_sts_q, irq_sts_d, irq_sts_clr_s;
    logic             irq_q;
    logic             rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [31:0]      rsp_rdata_q, rsp_rdata_d;
    logic             unused_addr_s;

    assign unused_addr_s = ^{bus.icb_cmd_addr[ADDR_WIDTH-1:11], bus.icb_cmd_addr[1:0]};

    // Address decode: [10] global space, [9:5] channel, [4:0] channel offset
    assign addr_s    = bus.icb_cmd_addr[10:0];
    assign chn_sel_s = addr_s[9:5];
    assign ofs_s     = addr_s[4:0];
    assign par_k_s   = ofs_s[3:2];
    assign chn_ok_s  = ~addr_s[10] & (int'(chn_sel_s) < CHN_N);
    assign is_ctrl_s = chn_ok_s & (ofs_s[4:2] == CTRL_OFS[4:2]);
    assign is_par_s  = chn_ok_s & (ofs_s[4] == PARAMS_OFS[4]) & (int'(par_k_s) < NWORDS);
    assign is_en_s   = (addr_s[10:2] == IRQ_EN_ADDR[10:2]);
    assign is_sts_s  = (addr_s[10:2] == IRQ_STS_ADDR[10:2]);
    assign mapped_s  = is_ctrl_s | is_par_s | is_en_s | is_sts_s;

    // Only one response may be outstanding
    assign cmd_ready_s = ~rsp_valid_q | bus.icb_rsp_ready;
    assign cmd_acc_s   = bus.icb_cmd_valid & cmd_ready_s;
    assign wr_s        = cmd_acc_s & ~bus.icb_cmd_read;
    assign bmask_s     = byte_mask(bus.icb_cmd_wmask);

    // Pick the addressed channel's status and params word
    always_comb begin
        sel_busy_s   = 1'b0;
        sel_idle_s   = 1'b0;
        sel_sticky_s = 1'b0;
        sel_par_s    = 32'h0000_0000;
        for (int c = 0; c < CHN_N; c++) begin
            sel_busy_s   |= busy_s[c]     & (int'(chn_sel_s) == c);
            sel_idle_s   |= blk_idle_i[c] & (int'(chn_sel_s) == c);
            sel_sticky_s |= sticky_s[c]   & (int'(chn_sel_s) == c);
            for (int k = 0; k < NWORDS; k++) begin
                sel_par_s |= ((int'(chn_sel_s) == c) && (int'(par_k_s) == k)) ?
                             params_s[c][k*32 +: 32] : 32'h0000_0000;
            end
        end
    end

    // Legality: starts and params writes are judged on the pre-edge state
    assign start_req_s = is_ctrl_s & bus.icb_cmd_wmask[0] & bus.icb_cmd_wdata[CTRL_START_BIT];
    assign clr_req_s   = is_ctrl_s & bus.icb_cmd_wmask[0] & bus.icb_cmd_wdata[CTRL_CLR_BIT];
    assign start_bad_s = start_req_s & (sel_busy_s | ~sel_idle_s);
    assign par_bad_s   = is_par_s & sel_busy_s;

    // Error flag and read data for the accepted command
    always_comb begin
        ctrl_rd_s                = 32'h0000_0000;
        ctrl_rd_s[CTRL_IDLE_BIT] = sel_idle_s;
        ctrl_rd_s[CTRL_DONE_BIT] = sel_sticky_s;
        ctrl_rd_s[CTRL_BUSY_BIT] = sel_busy_s;
        if (!mapped_s) begin
            err_s = 1'b1;
        end else if (!bus.icb_cmd_read && (start_bad_s || par_bad_s)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
        rdata_s = 32'h0000_0000;
        if (err_s || !bus.icb_cmd_read) rdata_s = 32'h0000_0000;
        else if (is_ctrl_s)             rdata_s = ctrl_rd_s;
        else if (is_par_s)              rdata_s = sel_par_s;
        else if (is_en_s)               rdata_s = 32'(irq_en_q);
        else if (is_sts_s)              rdata_s = 32'(irq_sts_q);
        else                            rdata_s = 32'h0000_0000;
    end

    for (genvar c = 0; c < CHN_N; c++) begin : g_chn
        logic hit_s;
        assign hit_s = wr_s & (int'(chn_sel_s) == c);

        blk_ctrl_chn #(.PARAMS_WIDTH(PARAMS_WIDTH)) u_chn (
            .clk           (clk),
            .rst_n         (rst_n),
            .start_i       (hit_s & start_req_s & ~start_bad_s),
            .clr_done_i    (hit_s & clr_req_s),
            .par_we_i      (hit_s & is_par_s & ~sel_busy_s),
            .par_word_i    (par_k_s),
            .par_wdata_i   (bus.icb_cmd_wdata),
            .par_bmask_i   (bmask_s),
            .done_i        (blk_done_i[c]),
            .busy_o        (busy_s[c]),
            .done_sticky_o (sticky_s[c]),
            .done_evt_o    (done_evt_s[c]),
            .start_o       (start_s[c]),
            .params_o      (params_s[c])
        );
    end

    // Interrupt enable write and status W1C; a new done wins over a clear
    always_comb begin
        irq_en_d      = irq_en_q;
        irq_sts_clr_s = '0;
        for (int i = 0; i < CHN_N; i++) begin
            if (wr_s && is_en_s && bmask_s[i]) irq_en_d[i] = bus.icb_cmd_wdata[i];
            else                               irq_en_d[i] = irq_en_q[i];
            irq_sts_clr_s[i] = wr_s & is_sts_s & bmask_s[i] & bus.icb_cmd_wdata[i];
        end
        irq_sts_d = (irq_sts_q & ~irq_sts_clr_s) | done_evt_s;
    end

    // Response holder: load on accept, drop on handshake, otherwise hold
    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        if (cmd_acc_s) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = rdata_s;
            rsp_err_d   = err_s;
        end else if (bus.icb_rsp_ready) begin
            rsp_valid_d = 1'b0;
        end else begin
            rsp_valid_d = rsp_valid_q;
        end
    end

    // Global registers: response, interrupt enable/status, irq
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0000_0000;
            rsp_err_q   <= 1'b0;
            irq_en_q    <= '0;
            irq_sts_q   <= '0;
            irq_q       <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            irq_en_q    <= irq_en_d;
            irq_sts_q   <= irq_sts_d;
            irq_q       <= |(irq_sts_q & irq_en_q);
        end
    end

    assign bus.icb_cmd_ready = cmd_ready_s;
    assign bus.icb_rsp_valid = rsp_valid_q;
    assign bus.icb_rsp_rdata = rsp_rdata_q;
    assign bus.icb_rsp_err   = rsp_err_q;
    assign blk_params_o      = params_s;
    assign blk_start_o       = start_s;
    assign irq_o             = irq_q;

endmodule

// File: tb/tb_icb_blk_ctrl_hub.sv
module tb_icb_blk_ctrl_hub;
    localparam int CHN_N = 4;
    localparam int PW    = 64;
    localparam int NW    = PW / 32;
    localparam int AW    = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icb_blk_ctrl_hub_if #(.ADDR_WIDTH(AW)) bus ();
    logic [CHN_N*PW-1:0] blk_params;
    logic [CHN_N-1:0]    blk_start, blk_idle, blk_done;
    logic                irq;

    icb_blk_ctrl_hub #(.CHN_N(CHN_N), .PARAMS_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus),
        .blk_params_o(blk_params), .blk_start_o(blk_start),
        .blk_idle_i(blk_idle), .blk_done_i(blk_done), .irq_o(irq)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Behavioural model state
    logic [CHN_N-1:0] m_busy, m_sticky, m_en, m_sts, m_start;
    logic [31:0]      m_par [CHN_N][NW];
    logic             m_irq, m_rv, m_rerr;
    logic [31:0]      m_rdata;

    task automatic chk(input string name, input logic [CHN_N*PW-1:0] act, input logic [CHN_N*PW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_sticky = '0; m_en = '0; m_sts = '0; m_start = '0;
        m_irq = 1'b0; m_rv = 1'b0; m_rerr = 1'b0; m_rdata = 32'h0;
        for (int c = 0; c < CHN_N; c++)
            for (int k = 0; k < NW; k++) m_par[c][k] = 32'h0;
    endtask

    // One clock edge of the register map as seen from software
    task automatic model_step();
        logic acc, err, n_irq;
        logic [CHN_N-1:0] ev, n_start, clr, w1c;
        logic [31:0] rd, bm, wd;
        int a, c, off, k;
        if (!rst_n) begin
            model_reset();
            return;
        end
        acc = bus.icb_cmd_valid && (!m_rv || bus.icb_rsp_ready);
        ev = blk_done & m_busy;
        n_irq = |(m_sts & m_en);
        n_start = '0; clr = '0; w1c = '0; err = 1'b0; rd = 32'h0;
        wd = bus.icb_cmd_wdata;
        for (int b = 0; b < 4; b++) bm[b*8 +: 8] = {8{bus.icb_cmd_wmask[b]}};
        if (acc) begin
            a = int'(bus.icb_cmd_addr[10:0]) & 'h7FC;
            c = a / 32;
            off = a % 32;
            if (a == 'h400) begin
                if (bus.icb_cmd_read) rd = 32'(m_en);
                else m_en = (m_en & ~bm[CHN_N-1:0]) | (wd[CHN_N-1:0] & bm[CHN_N-1:0]);
            end else if (a == 'h404) begin
                if (bus.icb_cmd_read) rd = 32'(m_sts);
                else w1c = wd[CHN_N-1:0] & bm[CHN_N-1:0];
            end else if (a >= 'h400 || c >= CHN_N) begin
                err = 1'b1;
            end else if (off == 0) begin
                if (bus.icb_cmd_read) rd = {29'h0, m_busy[c], m_sticky[c], blk_idle[c]};
                else if (bus.icb_cmd_wmask[0]) begin
                    if (wd[1]) clr[c] = 1'b1;
                    if (wd[0]) begin
                        if (m_busy[c] || !blk_idle[c]) err = 1'b1;
                        else n_start[c] = 1'b1;
                    end
                end
            end else if (off >= 16 && (off - 16) / 4 < NW) begin
                k = (off - 16) / 4;
                if (bus.icb_cmd_read) rd = m_par[c][k];
                else if (m_busy[c]) err = 1'b1;
                else m_par[c][k] = (m_par[c][k] & ~bm) | (wd & bm);
            end else begin
                err = 1'b1;
            end
        end
        m_sticky = (m_sticky & ~clr) | ev;
        m_sts    = (m_sts & ~w1c) | ev;
        m_busy   = (m_busy & ~ev) | n_start;
        m_start  = n_start;
        m_irq    = n_irq;
        if (acc) begin
            m_rv = 1'b1;
            m_rerr = err;
            m_rdata = (err || !bus.icb_cmd_read) ? 32'h0 : rd;
        end else if (bus.icb_rsp_ready) begin
            m_rv = 1'b0;
        end
    endtask

    function automatic logic [CHN_N*PW-1:0] exp_params();
        logic [CHN_N*PW-1:0] v;
        for (int c = 0; c < CHN_N; c++)
            for (int k = 0; k < NW; k++) v[c*PW + k*32 +: 32] = m_par[c][k];
        return v;
    endfunction

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmd_ready", bus.icb_cmd_ready, (!m_rv || bus.icb_rsp_ready));
            chk("rsp_valid", bus.icb_rsp_valid, m_rv);
            if (m_rv) begin
                chk("rsp_rdata", bus.icb_rsp_rdata, m_rdata);
                chk("rsp_err", bus.icb_rsp_err, m_rerr);
            end
            chk("blk_start", blk_start, m_start);
            chk("blk_params", blk_params, exp_params());
            chk("irq", irq, m_irq);
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_cmd(input bit rd, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [3:0] wm, output logic [31:0] rdata, output logic err);
        int n = 0;
        bus.icb_cmd_valid = 1'b1; bus.icb_cmd_read = rd; bus.icb_cmd_addr = addr;
        bus.icb_cmd_wdata = wd;   bus.icb_cmd_wmask = wm;
        while (!bus.icb_cmd_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL cmd_timeout addr=%h", addr);
        end
        tick();
        bus.icb_cmd_valid = 1'b0;
        rdata = bus.icb_rsp_rdata;
        err = bus.icb_rsp_err;
    endtask

    logic [31:0] rdv;
    logic        erv;

    initial begin
        bus.icb_cmd_valid = 1'b0; bus.icb_cmd_read = 1'b0; bus.icb_cmd_addr = '0;
        bus.icb_cmd_wdata = 32'h0; bus.icb_cmd_wmask = 4'h0; bus.icb_rsp_ready = 1'b1;
        blk_idle = '1; blk_done = '0;
        model_reset();
        chk_en = 1'b1;
        #12;
        chk("reset_rsp_valid", bus.icb_rsp_valid, 1'b0);
        chk("reset_params", blk_params, '0);
        chk("reset_irq", irq, 1'b0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Load ch1 params, enable its interrupt, start it
        do_cmd(1'b0, 32'h30, 32'hDEADBEEF, 4'hF, rdv, erv); chk("par0_err", erv, 1'b0);
        do_cmd(1'b0, 32'h34, 32'h12345678, 4'hF, rdv, erv); chk("par1_err", erv, 1'b0);
        do_cmd(1'b0, 32'h400, 32'h2, 4'hF, rdv, erv);
        do_cmd(1'b0, 32'h20, 32'h1, 4'hF, rdv, erv);
        chk("start_err", erv, 1'b0);
        chk("start_pulse", blk_start, 4'b0010);
        blk_idle[1] = 1'b0;
        tick();
        chk("start_once", blk_start, 4'b0000);
        chk("params_ch1", blk_params[127:64], 64'h12345678_DEADBEEF);
        do_cmd(1'b1, 32'h20, 32'h0, 4'h0, rdv, erv); chk("ctrl_busy", rdv, 32'h4);

        // Illegal accesses while BUSY
        do_cmd(1'b0, 32'h30, 32'h0, 4'hF, rdv, erv); chk("busy_par_err", erv, 1'b1);
        do_cmd(1'b0, 32'h20, 32'h1, 4'hF, rdv, erv); chk("busy_start_err", erv, 1'b1);
        chk("params_kept", blk_params[127:64], 64'h12345678_DEADBEEF);

        // Done -> sticky, status, irq one cycle later
        blk_idle = '1; blk_done = 4'b0010;
        tick();
        blk_done = '0;
        chk("irq_not_yet", irq, 1'b0);
        tick();
        chk("irq_set", irq, 1'b1);
        do_cmd(1'b1, 32'h20, 32'h0, 4'h0, rdv, erv);  chk("ctrl_done", rdv, 32'h3);
        do_cmd(1'b1, 32'h404, 32'h0, 4'h0, rdv, erv); chk("irq_sts", rdv, 32'h2);
        do_cmd(1'b0, 32'h404, 32'h2, 4'hF, rdv, erv);
        tick();
        chk("irq_cleared", irq, 1'b0);
        do_cmd(1'b0, 32'h20, 32'h2, 4'hF, rdv, erv);
        do_cmd(1'b1, 32'h20, 32'h0, 4'h0, rdv, erv);  chk("ctrl_clr", rdv, 32'h1);

        // Unmapped addresses
        do_cmd(1'b1, 32'hC0, 32'h0, 4'h0, rdv, erv);
        chk("chn_oob_err", erv, 1'b1); chk("chn_oob_data", rdv, 32'h0);
        do_cmd(1'b1, 32'h18, 32'h0, 4'h0, rdv, erv);
        chk("word_oob_err", erv, 1'b1); chk("word_oob_data", rdv, 32'h0);

        // Response back-pressure, then back-to-back reads
        tick();
        bus.icb_rsp_ready = 1'b0;
        bus.icb_cmd_valid = 1'b1; bus.icb_cmd_read = 1'b1; bus.icb_cmd_addr = 32'h30;
        tick();
        bus.icb_cmd_addr = 32'h34;
        for (int i = 0; i < 5; i++) begin
            chk("bp_ready", bus.icb_cmd_ready, 1'b0);
            chk("bp_data", bus.icb_rsp_rdata, 32'hDEADBEEF);
            tick();
        end
        bus.icb_rsp_ready = 1'b1;
        tick(); chk("b2b_0", bus.icb_rsp_rdata, 32'h12345678);
        bus.icb_cmd_addr = 32'h400;
        tick(); chk("b2b_1", bus.icb_rsp_rdata, 32'h2);
        bus.icb_cmd_addr = 32'h20;
        tick(); chk("b2b_2", bus.icb_rsp_rdata, 32'h1);
        bus.icb_cmd_valid = 1'b0;
        tick();

        // Reset while ch0 is BUSY with a start pulse and response pending
        do_cmd(1'b0, 32'h10, 32'hCAFEF00D, 4'hF, rdv, erv);
        tick();
        bus.icb_rsp_ready = 1'b0;
        do_cmd(1'b0, 32'h0, 32'h1, 4'hF, rdv, erv);
        chk("pre_rst_start", blk_start, 4'b0001);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_rsp_valid", bus.icb_rsp_valid, 1'b0);
        chk("rst_rsp_err", bus.icb_rsp_err, 1'b0);
        chk("rst_rdata", bus.icb_rsp_rdata, 32'h0);
        chk("rst_params", blk_params, '0);
        chk("rst_start", blk_start, 4'b0000);
        chk("rst_irq", irq, 1'b0);
        bus.icb_rsp_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        do_cmd(1'b0, 32'h0, 32'h1, 4'hF, rdv, erv);
        chk("post_rst_err", erv, 1'b0);
        chk("post_rst_start", blk_start, 4'b0001);

        // Randomised traffic against the model
        for (int n = 0; n < 3000; n++) begin
            int sel, c;
            logic [31:0] a;
            int offs [7] = '{0, 0, 4, 16, 20, 24, 28};
            sel = $urandom_range(0, 9);
            c = $urandom_range(0, 5);
            if (sel < 7)       a = 32'(c * 32 + offs[$urandom_range(0, 6)]);
            else if (sel == 7) a = 32'h400;
            else if (sel == 8) a = 32'h404;
            else               a = 32'h408;
            bus.icb_cmd_addr  = a | ($urandom() << 11);
            bus.icb_cmd_valid = ($urandom_range(0, 2) != 0);
            bus.icb_cmd_read  = $urandom_range(0, 1);
            bus.icb_cmd_wdata = $urandom();
            bus.icb_cmd_wmask = 4'($urandom_range(0, 15));
            bus.icb_rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < CHN_N; i++) begin
                blk_done[i] = ($urandom_range(0, 7) == 0);
                blk_idle[i] = ($urandom_range(0, 3) != 0);
            end
            tick();
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
